// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    localparam logic [15:0] MEM_RESP_BAD_DATA = 16'hDEAD;
    localparam int          MEM_RESP_MAX_WAIT = 7;
    localparam int          MEM_RESP_CNT_W    = $clog2(MEM_RESP_MAX_WAIT + 1);

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, read-first, no reset.
// Latency: rdata registered one edge after addr is presented.
// Backpressure: none; accepts a read or write every cycle.
module mem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [0:(1<<ADDR_W)-1];

    // Write on we, and always register the addressed word (old value on a write).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Arbitrates fetch and data requests onto one RAM with WAIT_CYCLES wait states.
// Latency: request-to-ack WAIT_CYCLES+2 cycles; one IDLE cycle between transactions.
// Backpressure: requests are only sampled in IDLE; optional MEM_RESP_BOUNDS_CHECK_EN adds range errors.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic        busy
);

    state_t                    state;
    state_t                    state_nxt;
    port_t                     port_q;
    logic [15:0]               addr_q;
    logic [15:0]               wdata_q;
    logic                      we_q;
    logic [MEM_RESP_CNT_W-1:0] cnt;

    logic                      grant;
    logic                      commit;
    logic                      oor;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [15:0]               ram_rdata;
    logic [15:0]               read_val;

    assign grant  = (state == IDLE) && (d_req || if_req);
    assign commit = (state == ACCESS) && (cnt == '0);

`ifdef MEM_RESP_BOUNDS_CHECK_EN
    assign oor = |addr_q[15:ADDR_W];
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr_q[15:ADDR_W];
    assign oor = 1'b0;
`endif

    // In IDLE the RAM is addressed straight from the winning request so the
    // registered RAM output already holds the right word even with zero wait states.
    assign ram_addr = (state == IDLE) ? (d_req ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0])
                                      : addr_q[ADDR_W-1:0];
    assign ram_we   = commit && we_q && !oor;
    assign read_val = oor ? MEM_RESP_BAD_DATA : ram_rdata;

    mem_array #(.ADDR_W(ADDR_W)) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant from IDLE, commit when the wait counter is exhausted, one ACK cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (d_req || if_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0)       state_nxt = ACK;
            ACK:                          state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Request latches, wait counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            port_q   <= PORT_IF;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            if_rdata <= 16'h0000;
            d_rdata  <= 16'h0000;
        end else begin
            if (grant) begin
                port_q  <= d_req ? PORT_D : PORT_IF;
                addr_q  <= d_req ? d_addr : if_addr;
                wdata_q <= d_wdata;
                we_q    <= d_req && d_we;
                cnt     <= MEM_RESP_CNT_W'(WAIT_CYCLES);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - MEM_RESP_CNT_W'(1);
            end

            if_ack <= commit && (port_q == PORT_IF);
            d_ack  <= commit && (port_q == PORT_D);
            err    <= commit && oor;
            busy   <= (state_nxt != IDLE);

            if (commit && !we_q) begin
                if (port_q == PORT_D) begin
                    d_rdata <= read_val;
                end else begin
                    if_rdata <= read_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) share one stimulus stream.
// Latency: expected ack timing derived from the wait-state count of each instance.
// Backpressure: requests are pulsed while all instances are idle.
module tb_mem_responder;

    localparam logic [15:0] BAD = 16'hDEAD;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    logic [2:0]  if_ack_v;
    logic [2:0]  d_ack_v;
    logic [2:0]  err_v;
    logic [2:0]  busy_v;
    logic [15:0] if_rdata_v [3];
    logic [15:0] d_rdata_v  [3];

    // Reference model: per-instance memory image and held read data.
    logic [15:0] mdl    [3][256];
    logic [15:0] exp_if [3];
    logic [15:0] exp_d  [3];

    int checks = 0;
    int errors = 0;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_v[0]), .if_ack(if_ack_v[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_v[0]), .d_ack(d_ack_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_v[1]), .if_ack(if_ack_v[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_v[1]), .d_ack(d_ack_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_v[2]), .if_ack(if_ack_v[2]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_v[2]), .d_ack(d_ack_v[2]), .err(err_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wv(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    function automatic bit is_oor(input logic [15:0] a);
        return BOUNDS_EN && (a[15:8] != 8'h00);
    endfunction

    task automatic chk(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input int inst, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%b expected=%b", tag, inst, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk1({tag, "_if_ack"}, i, if_ack_v[i], 1'b0);
            chk1({tag, "_d_ack"},  i, d_ack_v[i],  1'b0);
            chk1({tag, "_err"},    i, err_v[i],    1'b0);
            chk1({tag, "_busy"},   i, busy_v[i],   1'b0);
            chk({tag, "_if_rdata"}, i, if_rdata_v[i], 16'h0000);
            chk({tag, "_d_rdata"},  i, d_rdata_v[i],  16'h0000);
        end
    endtask

    // One transaction on one port, request held only for the grant edge,
    // then the request lines are scrambled to show the grant is latched.
    task automatic txn(input bit data, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        bit          oor;
        logic [15:0] val;
        oor = is_oor(addr);
        @(negedge clk);
        d_req = data; d_we = we; d_addr = addr; d_wdata = wdata;
        if_req = !data; if_addr = addr;
        for (int i = 0; i < 3; i++) begin
            if (data && we) begin
                if (!oor) mdl[i][addr[7:0]] = wdata;
            end else begin
                val = oor ? BAD : mdl[i][addr[7:0]];
                if (data) exp_d[i] = val; else exp_if[i] = val;
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0;
        d_addr = 16'($urandom); d_wdata = 16'($urandom); if_addr = 16'($urandom); d_we = 1'($urandom);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int i = 0; i < 3; i++) begin
                chk1("busy",   i, busy_v[i],   k <= wv(i) + 1);
                chk1("d_ack",  i, d_ack_v[i],  data && (k == wv(i) + 1));
                chk1("if_ack", i, if_ack_v[i], !data && (k == wv(i) + 1));
                chk1("err",    i, err_v[i],    oor && (k == wv(i) + 1));
                if (k == wv(i) + 1) begin
                    chk("d_rdata",  i, d_rdata_v[i],  exp_d[i]);
                    chk("if_rdata", i, if_rdata_v[i], exp_if[i]);
                end
            end
        end
    endtask

    // Simultaneous data load and fetch: data wins, fetch is regranted after one IDLE cycle.
    task automatic prio(input logic [15:0] a_d, input logic [15:0] a_if);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = a_d; if_req = 1'b1; if_addr = a_if;
        for (int i = 0; i < 3; i++) begin
            exp_d[i]  = is_oor(a_d)  ? BAD : mdl[i][a_d[7:0]];
            exp_if[i] = is_oor(a_if) ? BAD : mdl[i][a_if[7:0]];
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 6) if_req = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk1("prio_d_ack", i, d_ack_v[i], k == wv(i) + 1);
                chk1("prio_both",  i, d_ack_v[i] & if_ack_v[i], 1'b0);
                if (k <= 2 * wv(i) + 4)
                    chk1("prio_if_ack", i, if_ack_v[i], k == 2 * wv(i) + 4);
                if (k == wv(i) + 2)
                    chk1("prio_idle_gap", i, busy_v[i], 1'b0);
                if (k == wv(i) + 1)
                    chk("prio_d_rdata", i, d_rdata_v[i], exp_d[i]);
                if (k == 2 * wv(i) + 4)
                    chk("prio_if_rdata", i, if_rdata_v[i], exp_if[i]);
            end
        end
    endtask

    initial begin
        logic [15:0] ra;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 3; i++) begin exp_if[i] = '0; exp_d[i] = '0; end
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Store then fetch the same word; load data stays at its reset value.
        txn(1'b1, 1'b1, 16'h0005, 16'h1234);
        txn(1'b0, 1'b0, 16'h0005, 16'h0000);

        // Give every low address a known value.
        for (int a = 0; a < 16; a++) txn(1'b1, 1'b1, 16'(a), 16'($urandom));

        // Random mix of loads, stores and fetches, some with upper address bits set.
        for (int n = 0; n < 24; n++) begin
            ra = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra[15:8] = 8'($urandom_range(1, 255));
            case ($urandom_range(0, 2))
                0:       txn(1'b1, 1'b1, ra, 16'($urandom));
                1:       txn(1'b1, 1'b0, ra, 16'h0000);
                default: txn(1'b0, 1'b0, ra, 16'h0000);
            endcase
        end

        // Read-after-write as back-to-back transactions.
        txn(1'b1, 1'b1, 16'h0007, 16'hA5C3);
        txn(1'b1, 1'b0, 16'h0007, 16'h0000);

        // Out-of-range address: wraps, or errors under the bounds check.
        txn(1'b1, 1'b1, 16'h0105, 16'hBEEF);
        txn(1'b1, 1'b0, 16'h0005, 16'h0000);
        txn(1'b1, 1'b0, 16'h0105, 16'h0000);

        prio(16'h0003, 16'h0009);

        // Reset while a store is in flight: only the zero-wait instance has committed.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h5555;
        @(posedge clk); #1 d_req = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        mdl[0][8'h10] = 16'h5555;
        for (int i = 0; i < 3; i++) begin exp_if[i] = '0; exp_d[i] = '0; end
        #1 chk_all_zero("rst_access");
        @(posedge clk); #1 chk_all_zero("rst_hold");
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                chk1("post_rst_d_ack", i, d_ack_v[i], 1'b0);
                chk1("post_rst_busy",  i, busy_v[i],  1'b0);
            end
        end
        txn(1'b1, 1'b0, 16'h0010, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
